// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: CSR addresses, request op
// encodings, mstatus bit positions and the sequencer state enum.
package csr_pkg;

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMbadaddr = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;

  typedef enum logic [1:0] {
    OpIllegal = 2'b00,
    OpRw      = 2'b01,
    OpRs      = 2'b10,
    OpRc      = 2'b11
  } csr_op_e;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  typedef enum logic [3:0] {
    StIdle,
    StRd,
    StWr,
    StTRd,
    StTWr,
    StTVec,
    StMRd,
    StMWr,
    StMVec
  } state_e;

  // CSRs held inside the access unit rather than in the register file.
  function automatic logic is_local_csr(input logic [11:0] addr);
    return (addr == CsrMepc) || (addr == CsrMcause) || (addr == CsrMbadaddr);
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// Combinational read-modify-write evaluator for CSRRW/CSRRS/CSRRC.
// Ports:
//   old_val  - current CSR value
//   wdata    - rs1 value or zero-extended immediate
//   op       - request op (01 RW, 10 RS, 11 RC, 00 illegal)
//   addr     - CSR address (addr[11:10] == 2'b11 is read-only)
//   new_val  - value to write back
//   we       - a write must be performed
//   illegal  - request is illegal (reserved op or write to read-only CSR)
module csr_rmw
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      op,
  input  logic [11:0]     addr,
  output logic [XLEN-1:0] new_val,
  output logic            we,
  output logic            illegal
);

  logic read_only;
  logic no_write;

  always_comb begin
    read_only = (addr[11:10] == 2'b11);
    // RS/RC with a zero operand is a pure read, even on read-only CSRs.
    no_write  = ((op == OpRs) || (op == OpRc)) && (wdata == '0);
    illegal   = (op == OpIllegal) || (read_only && !no_write);
    we        = !illegal && !read_only && !no_write;
    unique case (op)
      OpRw:    new_val = wdata;
      OpRs:    new_val = old_val | wdata;
      OpRc:    new_val = old_val & ~wdata;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequencer between the execute stage and the CSR register file.
// Turns CSR instructions into read-modify-write cycles on the file port, and
// performs trap entry and MRET (mstatus update plus PC redirect).
// Ports:
//   clk, resetn           - clock; synchronous reset, active-high despite the name
//   req_*                 - CSR instruction request / accept handshake
//   rsp_*                 - one-cycle response pulse with old value and illegal flag
//   trap_*                - trap handshake with cause, pc, bad address
//   mret_valid/ready      - MRET handshake
//   redirect_valid/pc     - one-cycle PC redirect pulse
//   csr_addr/wdata/we     - register file access port; csr_rdata is its read bus
//   mstatus, mie, mip     - live values from the file
//   mepc, mcause, mbadaddr- locally owned registers fed to the file
//   irq_pending           - machine interrupt pending and enabled
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_badaddr,
  input  logic            mret_valid,
  output logic            mret_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mbadaddr,
  output logic            irq_pending
);

  state_e          state_q, state_d;
  logic [11:0]     addr_q, addr_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mbadaddr_q, mbadaddr_d;

  logic [XLEN-1:0] rmw_new;
  logic            rmw_we;
  logic            rmw_illegal;
  logic [XLEN-1:0] ms_trap, ms_mret, vec_pc;
  logic            we_raw, rsp_raw, redir_raw;
  logic            local_csr;

  csr_rmw #(
    .XLEN(XLEN)
  ) u_rmw (
    .old_val(old_q),
    .wdata  (wdata_q),
    .op     (op_q),
    .addr   (addr_q),
    .new_val(rmw_new),
    .we     (rmw_we),
    .illegal(rmw_illegal)
  );

  assign local_csr   = is_local_csr(addr_q);
  assign irq_pending = mstatus[MstatusMie] & (|(mie & mip));
  assign mepc        = mepc_q;
  assign mcause      = mcause_q;
  assign mbadaddr    = mbadaddr_q;

  assign trap_ready = (state_q == StIdle);
  assign mret_ready = (state_q == StIdle) && !trap_valid;
  assign req_ready  = (state_q == StIdle) && !trap_valid && !mret_valid;

  // Pulses are suppressed while reset is asserted so an in-flight write is dropped.
  assign csr_we         = we_raw & ~resetn;
  assign rsp_valid      = rsp_raw & ~resetn;
  assign redirect_valid = redir_raw & ~resetn;

  // mstatus images for trap entry and MRET, derived from the captured value.
  always_comb begin
    ms_trap                             = old_q;
    ms_trap[MstatusMpie]                = old_q[MstatusMie];
    ms_trap[MstatusMie]                 = 1'b0;
    ms_trap[MstatusMppHi:MstatusMppLo]  = 2'b11;
    ms_mret                             = old_q;
    ms_mret[MstatusMie]                 = old_q[MstatusMpie];
    ms_mret[MstatusMpie]                = 1'b1;
    ms_mret[MstatusMppHi:MstatusMppLo]  = 2'b11;
    vec_pc = {mtvec_q[XLEN-1:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && mcause_q[XLEN-1]) begin
      vec_pc = vec_pc + {mcause_q[XLEN-3:0], 2'b00};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mbadaddr_d  = mbadaddr_q;
    csr_addr    = '0;
    csr_wdata   = '0;
    we_raw      = 1'b0;
    rsp_raw     = 1'b0;
    rsp_rdata   = '0;
    rsp_illegal = 1'b0;
    redir_raw   = 1'b0;
    redirect_pc = '0;

    unique case (state_q)
      StIdle: begin
        if (trap_valid) begin
          csr_addr   = CsrMstatus;
          mepc_d     = {trap_pc[XLEN-1:2], 2'b00};
          mcause_d   = trap_cause;
          mbadaddr_d = trap_badaddr;
          state_d    = StTRd;
        end else if (mret_valid) begin
          csr_addr = CsrMstatus;
          state_d  = StMRd;
        end else if (req_valid) begin
          csr_addr = req_addr;
          addr_d   = req_addr;
          op_d     = req_op;
          wdata_d  = req_wdata;
          state_d  = StRd;
        end
      end
      StRd: begin
        csr_addr = addr_q;
        if (addr_q == CsrMepc) begin
          old_d = mepc_q;
        end else if (addr_q == CsrMcause) begin
          old_d = mcause_q;
        end else if (addr_q == CsrMbadaddr) begin
          old_d = mbadaddr_q;
        end else begin
          old_d = csr_rdata;
        end
        // Only single-cycle read latency is supported; any other value aborts.
        state_d = (RD_LAT == 1) ? StWr : StIdle;
      end
      StWr: begin
        csr_addr    = addr_q;
        csr_wdata   = rmw_new;
        we_raw      = rmw_we & ~local_csr;
        rsp_raw     = 1'b1;
        rsp_illegal = rmw_illegal;
        rsp_rdata   = rmw_illegal ? '0 : old_q;
        if (rmw_we && (addr_q == CsrMepc)) begin
          mepc_d = {rmw_new[XLEN-1:2], 2'b00};
        end
        if (rmw_we && (addr_q == CsrMcause)) begin
          mcause_d = rmw_new;
        end
        if (rmw_we && (addr_q == CsrMbadaddr)) begin
          mbadaddr_d = rmw_new;
        end
        state_d = StIdle;
      end
      StTRd: begin
        old_d = csr_rdata;
        // Issue the mtvec read now so its data arrives while the port writes mstatus.
        csr_addr = CsrMtvec;
        state_d  = StTWr;
      end
      StTWr: begin
        mtvec_d   = csr_rdata;
        csr_addr  = CsrMstatus;
        csr_wdata = ms_trap;
        we_raw    = 1'b1;
        state_d   = StTVec;
      end
      StTVec: begin
        redir_raw   = 1'b1;
        redirect_pc = vec_pc;
        state_d     = StIdle;
      end
      StMRd: begin
        csr_addr = CsrMstatus;
        old_d    = csr_rdata;
        state_d  = StMWr;
      end
      StMWr: begin
        csr_addr  = CsrMstatus;
        csr_wdata = ms_mret;
        we_raw    = 1'b1;
        state_d   = StMVec;
      end
      StMVec: begin
        redir_raw   = 1'b1;
        redirect_pc = mepc_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      old_q      <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mbadaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mbadaddr_q <= mbadaddr_d;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: a register file model with one-cycle
// read latency, a rule-level reference model, and a monitor that pops expected
// responses, writes and redirects as the DUT presents them.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        trap_valid, trap_ready;
  logic [31:0] trap_cause, trap_pc, trap_badaddr;
  logic        mret_valid, mret_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_we;
  logic [31:0] mstatus, mie, mip, mepc, mcause, mbadaddr;
  logic        irq_pending;

  always #5 clk = ~clk;

  csr_access_unit #(
    .XLEN  (32),
    .RD_LAT(1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_illegal   (rsp_illegal),
    .trap_valid    (trap_valid),
    .trap_ready    (trap_ready),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_badaddr  (trap_badaddr),
    .mret_valid    (mret_valid),
    .mret_ready    (mret_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_we        (csr_we),
    .csr_rdata     (csr_rdata),
    .mstatus       (mstatus),
    .mie           (mie),
    .mip           (mip),
    .mepc          (mepc),
    .mcause        (mcause),
    .mbadaddr      (mbadaddr),
    .irq_pending   (irq_pending)
  );

  // Register file environment: registered read, write on write_en, backdoor preload.
  logic [31:0] file_mem [4096];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) file_mem[bd_addr] <= bd_data;
    else if (csr_we) file_mem[csr_addr] <= csr_wdata;
    csr_rdata <= file_mem[csr_addr];
  end

  assign mstatus = file_mem[12'h300];
  assign mie     = file_mem[12'h304];
  assign mip     = file_mem[12'h344];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct { int cyc; logic [31:0] data; logic ill; } rsp_t;
  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } rd_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];
  bit   mon_en = 1'b0;

  // Reference model state.
  logic [31:0] ref_mem [bit [11:0]];
  logic [31:0] m_mepc = '0, m_mcause = '0, m_mbad = '0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mbad;
      default: return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin : mon
    rsp_t r;
    wr_t  w;
    rd_t  d;
    if (mon_en) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        else begin
          r = rsp_q.pop_front();
          check("rsp_cycle", cyc, r.cyc);
          check("rsp_rdata", rsp_rdata, r.data);
          check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, r.ill});
        end
      end
      if (csr_we) begin
        if (wr_q.size() == 0) check("write_unexpected", {31'd0, csr_we}, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("write_cycle", cyc, w.cyc);
          check("write_addr", {20'd0, csr_addr}, {20'd0, w.addr});
          check("write_data", csr_wdata, w.data);
        end
      end
      if (redirect_valid) begin
        if (rd_q.size() == 0) check("redirect_unexpected", {31'd0, redirect_valid}, 32'd0);
        else begin
          d = rd_q.pop_front();
          check("redirect_cycle", cyc, d.cyc);
          check("redirect_pc", redirect_pc, d.pc);
        end
      end
    end
  end

  task automatic set_file(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  function automatic logic sel_ready(input int kind);
    return (kind == 0) ? req_ready : (kind == 1) ? trap_ready : mret_ready;
  endfunction

  // kind: 0 CSR request, 1 trap, 2 MRET. crowd raises all three valids at once.
  task automatic issue(input int kind, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] cause,
                       input logic [31:0] pc, input logic [31:0] bad, input bit crowd);
    logic [31:0] old, nv, ms, mt, tgt;
    bit wr_att, ill;
    int acc, n;
    logic rdy;
    rsp_t r;
    wr_t  w;
    rd_t  d;
    old = '0; nv = '0; tgt = '0; wr_att = 0; ill = 0;
    if (kind == 0) begin
      old = m_read(addr);
      case (op)
        2'b01:   nv = wd;
        2'b10:   nv = old | wd;
        2'b11:   nv = old & ~wd;
        default: nv = old;
      endcase
      wr_att = (op == 2'b01) || ((op != 2'b00) && (wd != 0));
      ill    = (op == 2'b00) || ((addr[11:10] == 2'b11) && wr_att);
    end else if (kind == 1) begin
      ms  = m_read(12'h300);
      nv  = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
      mt  = m_read(12'h305);
      tgt = (mt & ~32'h3) + (((mt[1:0] == 2'b01) && cause[31]) ? (cause * 4) : 32'h0);
    end else begin
      ms  = m_read(12'h300);
      nv  = (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
      tgt = m_mepc;
    end

    @(negedge clk);
    req_valid  = (kind == 0) || crowd;
    trap_valid = (kind == 1) || crowd;
    mret_valid = (kind == 2) || crowd;
    req_op = op; req_addr = addr; req_wdata = wd;
    trap_cause = cause; trap_pc = pc; trap_badaddr = bad;
    #1;
    n = 0;
    rdy = sel_ready(kind);
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = sel_ready(kind);
    end
    if (!rdy) check("accept_timeout", {31'd0, rdy}, 32'd1);
    if (crowd) begin
      check("crowd_trap_ready", {31'd0, trap_ready}, 32'd1);
      check("crowd_mret_ready", {31'd0, mret_ready}, 32'd0);
      check("crowd_req_ready", {31'd0, req_ready}, 32'd0);
    end
    acc = cyc;

    if (kind == 0) begin
      r.cyc = acc + 2; r.data = ill ? 32'h0 : old; r.ill = ill;
      rsp_q.push_back(r);
      if (!ill && wr_att) begin
        case (addr)
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'h343: m_mbad = nv;
          default: begin
            ref_mem[addr] = nv;
            w.cyc = acc + 2; w.addr = addr; w.data = nv;
            wr_q.push_back(w);
          end
        endcase
      end
    end else begin
      if (kind == 1) begin
        m_mepc = pc & ~32'h3; m_mcause = cause; m_mbad = bad;
      end
      ref_mem[12'h300] = nv;
      w.cyc = acc + 2; w.addr = 12'h300; w.data = nv;
      wr_q.push_back(w);
      d.cyc = acc + 3; d.pc = tgt;
      rd_q.push_back(d);
    end

    @(posedge clk); #1;
    // Unaccepted sources are dropped here; busy-time input changes must be ignored.
    req_valid = 0; trap_valid = 0; mret_valid = 0;
    req_addr = 12'($urandom); req_wdata = $urandom; req_op = 2'($urandom);
    trap_cause = $urandom; trap_pc = $urandom; trap_badaddr = $urandom;
    repeat (4) @(negedge clk);
    check("mepc", mepc, m_mepc);
    check("mcause", mcause, m_mcause);
    check("mbadaddr", mbadaddr, m_mbad);
    check("irq_pending", {31'd0, irq_pending},
          {31'd0, m_read(12'h300)[3] & (|(m_read(12'h304) & m_read(12'h344)))});
    check("idle_trap_ready", {31'd0, trap_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pool [12];
    int n;
    pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h344, 12'h341,
             12'h342, 12'h343, 12'hF11, 12'hC00, 12'h7C0, 12'hB00};
    resetn = 1'b1;
    req_valid = 0; trap_valid = 0; mret_valid = 0;
    req_op = 0; req_addr = 0; req_wdata = 0;
    trap_cause = 0; trap_pc = 0; trap_badaddr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_csr_we", {31'd0, csr_we}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    check("rst_mbadaddr", mbadaddr, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mret_ready", {31'd0, mret_ready}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;

    for (int i = 0; i < 12; i++) set_file(pool[i], $urandom);
    mon_en = 1'b1;

    // Directed cases
    set_file(12'h304, 32'h80);
    issue(0, 2'b10, 12'h304, 32'h8, 0, 0, 0, 0);        // CSRRS -> old 0x80, write 0x88
    set_file(12'h300, 32'h8);
    issue(0, 2'b11, 12'h300, 32'h0, 0, 0, 0, 0);        // CSRRC 0 -> read only
    issue(0, 2'b01, 12'hF11, 32'h5, 0, 0, 0, 0);        // write to read-only -> illegal
    issue(0, 2'b00, 12'h304, 32'h1, 0, 0, 0, 0);        // reserved op -> illegal
    issue(0, 2'b10, 12'hF11, 32'h0, 0, 0, 0, 0);        // RS 0 to read-only is legal
    set_file(12'h300, 32'h8);
    set_file(12'h305, 32'h1000);
    issue(1, 0, 0, 0, 32'h2, 32'h1003, 32'hDEAD, 0);    // mstatus 0x1880, redirect 0x1000
    set_file(12'h300, 32'h8);
    set_file(12'h305, 32'h2001);
    issue(1, 0, 0, 0, 32'h80000007, 32'h1000, 32'h0, 0); // vectored -> 0x201C
    issue(2, 0, 0, 0, 0, 0, 0, 0);                       // MRET -> 0x1000, MIE=MPIE=1
    issue(0, 2'b01, 12'h341, 32'h12347, 0, 0, 0, 0);     // mepc aligned on write
    issue(0, 2'b10, 12'h342, 32'h40, 0, 0, 0, 0);
    issue(1, 2'b01, 12'h304, 32'h3, 32'h8000000B, 32'h2222, 32'h55, 1); // trap wins

    // Reset while the trap's mstatus write is on the port.
    @(negedge clk);
    trap_valid = 1; trap_cause = 32'h5; trap_pc = 32'h4444; trap_badaddr = 32'h77;
    #1;
    n = 0;
    while (!trap_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!trap_ready) check("rst_trap_accept", {31'd0, trap_ready}, 32'd1);
    @(posedge clk); #1;
    trap_valid = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_twr_csr_we", {31'd0, csr_we}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    m_mepc = 0; m_mcause = 0; m_mbad = 0;
    @(negedge clk);
    check("rst_twr_idle", {31'd0, req_ready}, 32'd1);
    check("rst_twr_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_twr_mepc", mepc, 32'd0);
    check("rst_twr_mcause", mcause, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_twr_mstatus_kept", mstatus, m_read(12'h300));

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int k;
      logic [31:0] wd, cause;
      k = $urandom_range(0, 99);
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cause = $urandom_range(0, 1) ? {1'b1, 27'd0, 4'($urandom)} : {28'd0, 4'($urandom)};
      if (k < 70) issue(0, 2'($urandom), pool[$urandom_range(0, 11)], wd, 0, 0, 0, 0);
      else if (k < 85) issue(1, 0, 0, 0, cause, $urandom, $urandom, 0);
      else issue(2, 0, 0, 0, 0, 0, 0, 0);
    end

    repeat (5) @(negedge clk);
    check("rsp_q_drained", rsp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("redirect_q_drained", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
